// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_pkg                                               |
// | Description : Size codes, access FSM states and lane helpers shared by the |
// |               memory-access stage.                                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~addr_lo[0];
            default: is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << addr_lo;
            SZ_HALF: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    // Right-aligned store data is copied into every lane; byte enables pick the live one.
    function automatic logic [31:0] store_replicate(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SZ_BYTE: store_replicate = {4{data[7:0]}};
            SZ_HALF: store_replicate = {2{data[15:0]}};
            default: store_replicate = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr_lo, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : byte_lane_ram                                                |
// | Description : Word array with per-byte write enables, synchronous write    |
// |               and asynchronous read. Contents are never reset.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module byte_lane_ram #(
    parameter int WORD_AW = 9
) (
    input  logic               clk,
    input  logic [3:0]         we,
    input  logic [WORD_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [0:(1<<WORD_AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : Pipeline MEM stage: byte-lane data memory, latency FSM with  |
// |               stall handshake, MEM/WB register and branch resolution.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 11,
    parameter int REG_W       = 5,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              Branch,
    input  logic              branch_ne,
    input  logic              zero_signal,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  reg_dest,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    output logic              mem_stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  reg_dest_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              misalign_out
);
    import mem_access_pkg::*;

    localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam bit              HAS_WAIT = (MEM_LATENCY > 0);
    localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

    logic [1:0]        addr_lo;
    logic              access;
    logic              aligned;
    logic              misalign;
    logic              go;
    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              stall;
    logic              complete;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic [31:0]       load_data;

    assign addr_lo  = alu_result[1:0];
    assign access   = MemRead | MemWrite;
    assign aligned  = is_aligned(mem_size, addr_lo);
    assign misalign = access & ~aligned;
    assign go       = access & aligned;

    assign PCSrc = Branch & (zero_signal ^ branch_ne);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (go && HAS_WAIT) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // The access completes on the first edge where the stall is released.
    always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        case (state)
            ST_IDLE: begin
                stall    = go & HAS_WAIT;
                complete = go & ~HAS_WAIT;
            end
            ST_WAIT: begin
                stall    = (cnt != '0);
                complete = go & (cnt == '0);
            end
        endcase
    end

    assign mem_stall = stall;
    assign ram_we    = (complete && MemWrite) ? byte_enable(mem_size, addr_lo) : 4'b0000;

    byte_lane_ram #(
        .WORD_AW (ADDR_W - 2)
    ) u_ram (
        .clk   (clock),
        .we    (ram_we),
        .addr  (alu_result[ADDR_W-1:2]),
        .wdata (store_replicate(in_data, mem_size)),
        .rdata (ram_rdata)
    );

    assign load_data = load_extend(ram_rdata, mem_size, addr_lo, mem_unsigned);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_out  <= '0;
            alu_result_out <= '0;
            reg_dest_out   <= '0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            misalign_out   <= 1'b0;
        end else begin
            alu_result_out <= alu_result;
            reg_dest_out   <= reg_dest;
            if (stall) begin
                read_data_out <= '0;
                MemToReg_out  <= 1'b0;
                RegWrite_out  <= 1'b0;
                misalign_out  <= 1'b0;
            end else begin
                read_data_out <= (complete && MemRead && !MemWrite) ? load_data : '0;
                MemToReg_out  <= MemToReg_in;
                RegWrite_out  <= RegWrite_in & ~misalign;
                misalign_out  <= misalign;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised successor to the pipeline memory-access stage. It holds a byte-addressed data memory with byte-lane writes and sized, sign/zero-extended loads. A configurable-latency access FSM drives a mem_stall handshake back to the pipeline. It also owns the MEM/WB pipeline register and the branch-resolution PCSrc output, and sits between EX/MEM and write-back.

Parameters:
DATA_W, 32, data path width in bits (fixed multiple of 8; 32 is the supported value)
ADDR_W, 11, byte-address width; memory depth = 2**(ADDR_W-2) words
REG_W, 5, register-destination index width
MEM_LATENCY, 2, extra wait cycles per memory access (0 = single-cycle)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
MemRead  in  1  load request
MemWrite  in  1  store request
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
Branch  in  1  branch instruction in MEM
branch_ne  in  1  1 = BNE semantics, 0 = BEQ
zero_signal  in  1  ALU zero flag
alu_result  in  DATA_W  byte address / ALU result
in_data  in  DATA_W  store data, right-aligned
reg_dest  in  REG_W  destination register
MemToReg_in  in  1  WB control
RegWrite_in  in  1  WB control
mem_stall  out  1  hold upstream stages; combinational
PCSrc  out  1  take branch; combinational
read_data_out  out  DATA_W  MEM/WB load data, extended
alu_result_out  out  DATA_W  MEM/WB alu result
reg_dest_out  out  REG_W  MEM/WB destination
MemToReg_out  out  1  MEM/WB control
RegWrite_out  out  1  MEM/WB control
misalign_out  out  1  MEM/WB: misaligned access flagged

Behaviour:
- Reset (async, reset_n=0): all MEM/WB outputs 0, FSM to IDLE, wait counter 0. Memory contents are not reset. Reset during WAIT aborts the access; no write is committed.
- PCSrc = Branch & (zero_signal ^ branch_ne). It is combinational and independent of the FSM.
- Access request: MemRead|MemWrite, address aligned. Alignment rules: half needs addr[0]=0; word needs addr[1:0]=00.
- Misaligned request: no memory write, no stall. At the next edge the MEM/WB register loads misalign_out=1 and RegWrite_out=0; the other fields load normally.
- MemRead and MemWrite both high: write only. read_data_out loads 0.
- FSM states: IDLE, WAIT.
  - IDLE, aligned access, MEM_LATENCY>0: mem_stall=1 combinationally. Next state WAIT, counter loaded with MEM_LATENCY-1.
  - WAIT: mem_stall=1 while counter!=0, and the counter decrements each edge. When counter==0, mem_stall=0; at that edge the access completes, the MEM/WB register captures, and the state returns to IDLE.
  - Upstream holds all inputs stable while mem_stall=1.
- MEM_LATENCY=0: no WAIT state, mem_stall is always 0, and every access completes at the edge it is presented.
- Store commit: exactly once, at the completing edge. Byte enables come from mem_size and addr[1:0]; in_data is replicated to the selected lanes.
- Load: the word is read at index addr[ADDR_W-1:2]. The lane is selected by addr[1:0] and extended per mem_unsigned.
- Bubble rule: on every edge where mem_stall=1, MEM/WB loads RegWrite_out=0, MemToReg_out=0, misalign_out=0. This prevents duplicate write-back.
- Non-memory instructions pass through the MEM/WB register with 1-cycle latency. read_data_out loads 0.
- Address bits above ADDR_W are ignored; addresses wrap.

Decomposition:
- Shared package mem_access_pkg contains:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - functions: byte_enable(size, addr_lo) and load_extend(word, size, addr_lo, unsigned).
- One sub-module, byte_lane_ram: word array with 4 byte-write enables, synchronous write, asynchronous read.

Test Plan:
1. MEM_LATENCY=0. SW 0xDEADBEEF @0x10, then LW @0x10 -> read_data_out=0xDEADBEEF the cycle after the LW; mem_stall never 1.
2. MEM_LATENCY=2. LW @0x10 -> mem_stall=1 for 2 cycles, RegWrite_out=0 on those edges, then 0xDEADBEEF with RegWrite_out=1 exactly once.
3. SB 0x7F @0x13, then LB @0x13 -> 0x0000007F. Then SB 0x80 @0x12 and LB @0x12 -> 0xFFFFFF80; LBU @0x12 -> 0x00000080; word @0x10 = 0x7F80BEEF.
4. LH @0x11 -> misalign_out=1, RegWrite_out=0, no stall. SW @0x12 -> memory unchanged.
5. Branch=1, zero_signal=1: branch_ne=0 -> PCSrc=1; branch_ne=1 -> PCSrc=0.
6. SW 0x12345678 @0x20 with MEM_LATENCY=2; pulse reset_n low in the first WAIT cycle -> word @0x20 unchanged, all outputs 0, state IDLE.
